dsp_mac_sequencer: RTL and testbench

- Job-level controller that runs one DSP48A1-style slice (`dsp`) as a multiply-accumulate engine computing sum(A[i]*B[i]) for i = 0..LEN-1.
- Accepts a job command and a valid/ready operand stream, and drives the slice's A/B, OPMODE and clock-enable pins.
- Tracks the slice pipeline with a tag shift register, so stream bubbles never corrupt the accumulator.
- Returns the 48-bit P value through a valid/ready result port.

---
 rtl/dsp_pkg.sv | 32 +++
 rtl/dsp_tag_pipe.sv | 40 ++++
 rtl/dsp_mac_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48A1 multiply-accumulate sequencer:
// opmode field encodings, FSM state codes and the pipeline tag type.
package dsp_pkg;

    localparam logic [1:0] OPX_ZERO = 2'b00;
    localparam logic [1:0] OPX_M    = 2'b01;
    localparam logic [1:0] OPZ_ZERO = 2'b00;
    localparam logic [1:0] OPZ_P    = 2'b10;

    localparam logic [7:0] OPMODE_FIRST_DEF = {4'b0000, OPZ_ZERO, OPX_M};
    localparam logic [7:0] OPMODE_ACC_DEF   = {4'b0000, OPZ_P, OPX_M};

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;

    typedef struct packed {
        logic v;
        logic first;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '{v: 1'b0, first: 1'b0};

    function automatic logic [7:0] opmode_sel(input tag_t tag,
                                              input logic [7:0] op_first,
                                              input logic [7:0] op_acc);
        return tag.first ? op_first : op_acc;
    endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// MAC_LAT+1 deep tag shift register that shadows the slice pipeline.
// The "first" bit is only needed up to the opmode tap, so it is not carried further.
module dsp_tag_pipe
    import dsp_pkg::*;
#(
    parameter int MAC_LAT = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  tag_t tag_in,
    output tag_t opm_tag,
    output logic cep_v,
    output logic any_valid
);

    localparam int DEPTH   = MAC_LAT + 1;
    localparam int OPM_TAP = MAC_LAT - 2;

    logic [DEPTH-1:0] v_r;
    logic [OPM_TAP:0] first_r;

    // Shift a new tag in every cycle; bubbles enter as v=0
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            v_r     <= {DEPTH{1'b0}};
            first_r <= {(OPM_TAP + 1){1'b0}};
        end else begin
            v_r        <= {v_r[DEPTH-2:0], tag_in.v};
            first_r[0] <= tag_in.first;
            for (int i = 1; i <= OPM_TAP; i++) begin
                first_r[i] <= first_r[i-1];
            end
        end
    end

    assign opm_tag   = '{v: v_r[OPM_TAP], first: first_r[OPM_TAP]};
    assign cep_v     = v_r[MAC_LAT-1];
    assign any_valid = |v_r;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Job-level controller running one DSP48A1 slice as a sum(A[i]*B[i]) engine.
// Operand stream bubbles are tracked with tags so the accumulator only advances on real products.
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int         LW           = 10,
    parameter int         MAC_LAT      = 2,
    parameter logic [7:0] OPMODE_FIRST = OPMODE_FIRST_DEF,
    parameter logic [7:0] OPMODE_ACC   = OPMODE_ACC_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [LW-1:0] LEN,
    output logic          BUSY,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [17:0]   IN_A,
    input  logic [17:0]   IN_B,
    output logic [17:0]   DSP_A,
    output logic [17:0]   DSP_B,
    output logic [7:0]    DSP_OPMODE,
    output logic          DSP_CEOPMODE,
    output logic          DSP_CEAB,
    output logic          DSP_CEP,
    output logic          DSP_RST,
    input  logic [47:0]   DSP_P,
    output logic [47:0]   RESULT,
    output logic          RESULT_VALID,
    input  logic          RESULT_READY
);

    localparam logic [LW-1:0] REM_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] REM_ONE  = {{(LW-1){1'b0}}, 1'b1};

    logic [2:0]    state_r;
    logic [LW-1:0] rem_r;
    logic          first_pending_r;
    logic          busy_r;
    logic          in_ready_r;
    logic [47:0]   result_r;
    logic          result_valid_r;
    logic [17:0]   dsp_a_r;
    logic [17:0]   dsp_b_r;
    logic [7:0]    dsp_opmode_r;
    logic          dsp_ceopmode_r;
    logic          dsp_ceab_r;
    logic          dsp_cep_r;
    logic [1:0]    rst_sh_r;

    logic xfer_s;
    tag_t tag_in_s;
    tag_t opm_tag_s;
    logic cep_v_s;
    logic any_valid_s;

    assign xfer_s = IN_VALID & in_ready_r;

    // Tag for the operand pair entering DSP_A/DSP_B this cycle
    always_comb begin
        tag_in_s = TAG_BUBBLE;
        if (xfer_s) begin
            tag_in_s.v     = 1'b1;
            tag_in_s.first = first_pending_r;
        end else begin
            tag_in_s = TAG_BUBBLE;
        end
    end

    dsp_tag_pipe #(.MAC_LAT(MAC_LAT)) u_tag_pipe (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .tag_in    (tag_in_s),
        .opm_tag   (opm_tag_s),
        .cep_v     (cep_v_s),
        .any_valid (any_valid_s)
    );

    // Job FSM: command capture, operand counting, drain and result handshake
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r         <= ST_IDLE;
            rem_r           <= REM_ZERO;
            first_pending_r <= 1'b0;
            busy_r          <= 1'b0;
            in_ready_r      <= 1'b0;
            result_r        <= 48'd0;
            result_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        busy_r <= 1'b1;
                        if (LEN != REM_ZERO) begin
                            state_r         <= ST_RUN;
                            rem_r           <= LEN;
                            in_ready_r      <= 1'b1;
                            first_pending_r <= 1'b1;
                        end else begin
                            state_r        <= ST_OUT;
                            result_r       <= 48'd0;
                            result_valid_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        rem_r           <= rem_r - REM_ONE;
                        first_pending_r <= 1'b0;
                        if (rem_r == REM_ONE) begin
                            in_ready_r <= 1'b0;
                            state_r    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!any_valid_s) begin
                        state_r <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    result_r       <= DSP_P;
                    result_valid_r <= 1'b1;
                    state_r        <= ST_OUT;
                end
                ST_OUT: begin
                    if (RESULT_READY) begin
                        result_valid_r <= 1'b0;
                        busy_r         <= 1'b0;
                        state_r        <= ST_IDLE;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    busy_r         <= 1'b0;
                    in_ready_r     <= 1'b0;
                    result_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Operand registers and slice enables; opmode is loaded one stage ahead of P
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dsp_a_r        <= 18'd0;
            dsp_b_r        <= 18'd0;
            dsp_opmode_r   <= 8'h00;
            dsp_ceopmode_r <= 1'b0;
            dsp_cep_r      <= 1'b0;
            dsp_ceab_r     <= 1'b0;
        end else begin
            if (xfer_s) begin
                dsp_a_r <= IN_A;
                dsp_b_r <= IN_B;
            end else begin
                dsp_a_r <= 18'd0;
                dsp_b_r <= 18'd0;
            end
            dsp_opmode_r   <= opmode_sel(opm_tag_s, OPMODE_FIRST, OPMODE_ACC);
            dsp_ceopmode_r <= opm_tag_s.v;
            dsp_cep_r      <= cep_v_s;
            dsp_ceab_r     <= 1'b1;
        end
    end

    // Slice reset held for the reset cycle and the one after it
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rst_sh_r <= 2'b11;
        end else begin
            rst_sh_r <= {rst_sh_r[0], 1'b0};
        end
    end

    assign BUSY         = busy_r;
    assign IN_READY     = in_ready_r;
    assign RESULT       = result_r;
    assign RESULT_VALID = result_valid_r;
    assign DSP_A        = dsp_a_r;
    assign DSP_B        = dsp_b_r;
    assign DSP_OPMODE   = dsp_opmode_r;
    assign DSP_CEOPMODE = dsp_ceopmode_r;
    assign DSP_CEAB     = dsp_ceab_r;
    assign DSP_CEP      = dsp_cep_r;
    assign DSP_RST      = rst_sh_r[1];

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice model.
module tb_dsp_mac_sequencer;

    localparam int LW      = 10;
    localparam int MAC_LAT = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [LW-1:0] LEN = '0;
    logic          BUSY;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [17:0]   IN_A = 18'd0;
    logic [17:0]   IN_B = 18'd0;
    logic [17:0]   DSP_A;
    logic [17:0]   DSP_B;
    logic [7:0]    DSP_OPMODE;
    logic          DSP_CEOPMODE;
    logic          DSP_CEAB;
    logic          DSP_CEP;
    logic          DSP_RST;
    logic [47:0]   DSP_P;
    logic [47:0]   RESULT;
    logic          RESULT_VALID;
    logic          RESULT_READY = 1'b0;

    always #5 CLK = ~CLK;

    dsp_mac_sequencer #(.LW(LW), .MAC_LAT(MAC_LAT)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN), .BUSY(BUSY),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE),
        .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_CEAB(DSP_CEAB), .DSP_CEP(DSP_CEP),
        .DSP_RST(DSP_RST), .DSP_P(DSP_P), .RESULT(RESULT),
        .RESULT_VALID(RESULT_VALID), .RESULT_READY(RESULT_READY)
    );

    // Slice model: A1/B1 -> M -> P, OPMODEREG=1, CARRYIN tied low
    logic signed [17:0] a1_r = 18'sd0;
    logic signed [17:0] b1_r = 18'sd0;
    logic signed [35:0] m_r  = 36'sd0;
    logic [7:0]         opm_r = 8'h00;
    logic [47:0]        p_r  = 48'd0;
    logic [47:0]        x_mux;
    logic [47:0]        z_mux;

    assign DSP_P = p_r;
    assign x_mux = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
    assign z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;

    always @(posedge CLK) begin
        if (DSP_RST === 1'b1) begin
            a1_r <= 18'sd0; b1_r <= 18'sd0; m_r <= 36'sd0; opm_r <= 8'h00; p_r <= 48'd0;
        end else begin
            if (DSP_CEAB === 1'b1) begin
                a1_r <= DSP_A;
                b1_r <= DSP_B;
                m_r  <= a1_r * b1_r;
            end
            if (DSP_CEOPMODE === 1'b1) opm_r <= DSP_OPMODE;
            if (DSP_CEP === 1'b1) p_r <= opm_r[7] ? (z_mux - x_mux) : (z_mux + x_mux);
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cep_cnt = 0;
    int last_xfer_edge = 0;
    int rv_rise = 0;
    logic rv_q = 1'b0;
    logic [47:0] exp_q[$];
    logic [7:0]  opm_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: event bookkeeping plus scoreboard pop on every result handshake
    always @(negedge CLK) begin
        if (IN_VALID === 1'b1 && IN_READY === 1'b1) last_xfer_edge = cyc + 1;
        if (RESULT_VALID === 1'b1 && rv_q !== 1'b1) rv_rise = cyc;
        rv_q = RESULT_VALID;
        if (DSP_CEP === 1'b1) cep_cnt++;
        if (DSP_CEOPMODE === 1'b1) opm_log.push_back(DSP_OPMODE);
        if (RESULT_VALID === 1'b1 && RESULT_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got result 0x%0h, required no result", RESULT);
            end else begin
                chk("sb_result", {16'd0, RESULT}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input int len, input logic [47:0] expv, input bit push);
        START = 1'b1;
        LEN   = len[LW-1:0];
        tick();
        START = 1'b0;
        if (push) exp_q.push_back(expv);
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b);
        int n = 0;
        IN_A = a; IN_B = b; IN_VALID = 1'b1;
        while (IN_READY !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (IN_READY !== 1'b1) chk("in_ready_timeout", 64'(IN_READY), 64'd1);
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic collect(input int delay);
        int n = 0;
        bit held = 1'b1;
        while (RESULT_VALID !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (RESULT_VALID !== 1'b1) begin
            chk("result_timeout", 64'(RESULT_VALID), 64'd1);
        end else begin
            for (int i = 0; i < delay; i++) begin
                tick();
                if (RESULT_VALID !== 1'b1) held = 1'b0;
            end
            if (delay > 0) chk("result_hold", 64'(held), 64'd1);
            RESULT_READY = 1'b1;
            tick();
            RESULT_READY = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        RST_N = 1'b0;
        tick(); tick();
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_in_ready", 64'(IN_READY), 64'd0);
        chk("rst_valid", 64'(RESULT_VALID), 64'd0);
        chk("rst_result", 64'(RESULT), 64'd0);
        chk("rst_opmode", 64'(DSP_OPMODE), 64'h00);
        chk("rst_cep", 64'(DSP_CEP), 64'd0);
        chk("rst_dsp_rst", 64'(DSP_RST), 64'd1);
        RST_N = 1'b1;
        tick(); tick(); tick();
        chk("ceab_on", 64'(DSP_CEAB), 64'd1);

        // Gap-free LEN=4: 1*2+3*4+5*6+7*8 = 100
        opm_log.delete(); cep_cnt = 0;
        start_job(4, 48'd100, 1'b1);
        chk("busy_run", 64'(BUSY), 64'd1);
        send(18'd1, 18'd2); send(18'd3, 18'd4); send(18'd5, 18'd6); send(18'd7, 18'd8);
        collect(0);
        chk("latency", 64'(rv_rise - last_xfer_edge), 64'(MAC_LAT + 3));
        chk("busy_clear1", 64'(BUSY), 64'd0);
        chk("opm_count", 64'(opm_log.size()), 64'd4);
        if (opm_log.size() == 4) begin
            chk("opm0", 64'(opm_log[0]), 64'h01);
            chk("opm1", 64'(opm_log[1]), 64'h09);
            chk("opm2", 64'(opm_log[2]), 64'h09);
            chk("opm3", 64'(opm_log[3]), 64'h09);
        end
        chk("cep_cnt4", 64'(cep_cnt), 64'd4);

        // LEN=3 with 2-cycle bubbles: 100+6+16 = 122
        tick(); cep_cnt = 0;
        start_job(3, 48'd122, 1'b1);
        send(18'd10, 18'd10); tick(); tick();
        send(18'd2, 18'd3); tick(); tick();
        send(18'd4, 18'd4);
        collect(0);
        chk("cep_cnt3", 64'(cep_cnt), 64'd3);

        // LEN=0: immediate zero result, no slice activity
        tick(); cep_cnt = 0;
        start_job(0, 48'd0, 1'b1);
        chk("len0_valid", 64'(RESULT_VALID), 64'd1);
        chk("len0_busy", 64'(BUSY), 64'd1);
        collect(0);
        chk("len0_busy_clear", 64'(BUSY), 64'd0);
        chk("len0_cep", 64'(cep_cnt), 64'd0);

        // Back-to-back: 9+16 = 25 with delayed READY and an ignored START, then 25
        tick();
        start_job(2, 48'd25, 1'b1);
        send(18'd3, 18'd3); send(18'd4, 18'd4);
        START = 1'b1; LEN = 10'd1; tick(); START = 1'b0;
        collect(5);
        start_job(1, 48'd25, 1'b1);
        send(18'd5, 18'd5);
        collect(0);

        // Mid-run reset aborts the job silently
        tick();
        start_job(4, 48'd0, 1'b0);
        send(18'd9, 18'd9); send(18'd9, 18'd9);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_valid", 64'(RESULT_VALID), 64'd0);
        chk("abort_in_ready", 64'(IN_READY), 64'd0);
        chk("abort_dsp_rst0", 64'(DSP_RST), 64'd1);
        tick();
        chk("abort_dsp_rst1", 64'(DSP_RST), 64'd1);
        tick();
        chk("abort_dsp_rst2", 64'(DSP_RST), 64'd0);
        start_job(1, 48'd42, 1'b1);
        send(18'd6, 18'd7);
        collect(0);

        // Large operands: 2 * 0x1FFFF^2 = 0x7FFF80002, result held 10 cycles
        tick();
        start_job(2, 48'h7FFF80002, 1'b1);
        send(18'h1FFFF, 18'h1FFFF); send(18'h1FFFF, 18'h1FFFF);
        collect(10);

        tick(); tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
